nes_pad_reader: RTL

NES_PAD_READER -- requirements
Module: nes_pad_reader

---
 rtl/nes_pad_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/nes_pad_reader.sv
// NES pad poller: every POLL_TICKS cycles pulses pad_latch, clocks out eight bits, presents them on buttons.
// Define PAD_DEBOUNCE_EN so that buttons only change once two consecutive frames agree.

module nes_pad_reader #(
   parameter int HALF_TICKS = 128,
   parameter int POLL_TICKS = 357954
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pad_latch,
   output logic       pad_clk,
   input  logic       pad_data,
   output logic [7:0] buttons,
   output logic       valid
);

   localparam int POLL_W  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam int PHASE_W = $clog2(2 * HALF_TICKS);

   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

   state_t             state, state_next;
   logic [POLL_W-1:0]  poll_cnt;
   logic [PHASE_W-1:0] phase_cnt, phase_next;
   logic [2:0]         bit_idx, bit_next;
   logic [7:0]         shift_reg;
   logic [1:0]         sync;
   logic               tick;
   logic               phase_last;
   logic               sample_now;
   logic               frame_end;

   assign tick       = (poll_cnt == POLL_W'(POLL_TICKS - 1));
   assign phase_last = (phase_cnt == PHASE_W'(2 * HALF_TICKS - 1));
   assign sample_now = (state == SHIFT) && (phase_cnt == PHASE_W'(HALF_TICKS - 1));
   assign frame_end  = (state_next == DONE);

   // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values; combinational blocks use blocking (=).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], pad_data};
      end
   end

   // The poll counter free-runs regardless of FSM state, so frame starts stay on a fixed grid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poll_cnt <= '0;
      end else if (tick) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + 1'b1;
      end
   end

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
   always_comb begin
      state_next = state;
      phase_next = phase_cnt;
      bit_next   = bit_idx;
      case (state)
         IDLE: begin
            phase_next = '0;
            bit_next   = '0;
            if (tick && enable) state_next = LATCH;
         end
         LATCH: begin
            if (phase_last) begin
               phase_next = '0;
               bit_next   = '0;
               state_next = SHIFT;
            end else begin
               phase_next = phase_cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (phase_last) begin
               phase_next = '0;
               if (bit_idx == 3'd7) state_next = DONE;
               else                 bit_next   = bit_idx + 3'd1;
            end else begin
               phase_next = phase_cnt + 1'b1;
            end
         end
         default: begin
            phase_next = '0;
            bit_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // Pad-facing outputs are registered from next-state values so the lines never glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         phase_cnt <= '0;
         bit_idx   <= '0;
         pad_latch <= 1'b0;
         pad_clk   <= 1'b1;
         valid     <= 1'b0;
      end else begin
         state     <= state_next;
         phase_cnt <= phase_next;
         bit_idx   <= bit_next;
         pad_latch <= (state_next == LATCH);
         pad_clk   <= !((state_next == SHIFT) && (phase_next < PHASE_W'(HALF_TICKS)));
         valid     <= (state_next == DONE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= 8'h00;
      end else if (sample_now) begin
         shift_reg[bit_idx] <= ~sync[1];
      end
   end

`ifdef PAD_DEBOUNCE_EN
   logic [7:0] prev_frame;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_frame <= 8'h00;
         buttons    <= 8'h00;
      end else if (frame_end) begin
         if (shift_reg == prev_frame) buttons <= shift_reg;
         prev_frame <= shift_reg;
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buttons <= 8'h00;
      end else if (frame_end) begin
         buttons <= shift_reg;
      end
   end
`endif

endmodule
